// File: rtl/axi_err_responder_pkg.sv
// -----------------------------------------------------------------------------
// axi_err_responder_pkg
// Shared constants for the AXI4 terminating error responder: AXI response
// encodings, the ATOP bit that signals an owed R response, fixed AXI field
// widths, and a pointer-width helper for the transaction queues.
// -----------------------------------------------------------------------------
package axi_err_responder_pkg;

    // AXI4 xRESP encodings
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // AXI5 ATOP: bit 5 set means the atomic also returns read data on R
    localparam int unsigned ATOP_W      = 6;
    localparam int unsigned ATOP_R_RESP = 5;

    // AXI burst length field width
    localparam int unsigned LEN_W = 8;

    // Pointer width for a queue of the given depth (at least one bit)
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/axi_err_responder_fifo.sv
// -----------------------------------------------------------------------------
// axi_err_responder_fifo
// Registered (non fall-through) FIFO used for the write-ID and read queues.
// A pushed entry becomes visible at data_o on the cycle after the push.
// Callers must not push when full or pop when empty.
//
// Ports:
//   clk      in   clock
//   rst_n    in   asynchronous reset, active-high; empties the queue
//   push_i   in   write data_i at the tail
//   data_i   in   DataWidth  entry to store
//   pop_i    in   drop the head entry
//   full_o   out  Depth entries stored
//   empty_o  out  no entries stored
//   data_o   out  DataWidth  head entry (undefined while empty)
// -----------------------------------------------------------------------------
module axi_err_responder_fifo
    import axi_err_responder_pkg::*;
#(
    parameter int unsigned DataWidth = 8,
    parameter int unsigned Depth     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 pop_i,
    output logic                 full_o,
    output logic                 empty_o,
    output logic [DataWidth-1:0] data_o
);

    localparam int unsigned PtrW = ptr_width(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [DataWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]      cnt_q, cnt_d;

    assign full_o  = (cnt_q == CntW'(Depth));
    assign empty_o = (cnt_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        // Explicit wrap so non power-of-two depths work
        if (push_i) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage carries no reset so it can map onto distributed/block RAM;
    // the counters above are what define emptiness.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/axi_err_responder.sv
// -----------------------------------------------------------------------------
// axi_err_responder
// AXI4 terminating slave. Accepts every request, sinks all write data and
// answers every transaction with a fixed response code (RespVal) and fixed read
// data (RespData). Responses come back strictly in acceptance order.
//
// Ports:
//   clk, rst_n                     clock; asynchronous active-high reset
//   aw_valid/aw_ready, aw_id,
//   aw_len, aw_atop                write address channel
//   w_valid/w_ready, w_last        write data channel (data itself discarded)
//   b_valid/b_ready, b_id, b_resp  write response channel
//   ar_valid/ar_ready, ar_id,
//   ar_len                         read address channel
//   r_valid/r_ready, r_id, r_data,
//   r_resp, r_last                 read data channel
//
// Every output, readies included, is forced low while rst_n is high.
// -----------------------------------------------------------------------------
module axi_err_responder
    import axi_err_responder_pkg::*;
#(
    parameter int unsigned AxiIdWidth   = 4,
    parameter int unsigned AxiDataWidth = 64,
    parameter int unsigned MaxTrans     = 8,
    parameter logic [1:0]  RespVal      = RESP_DECERR,
    parameter logic [63:0] RespData     = 64'hCA11_AB1E_BAD_CAB1E
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // AW
    input  logic                    aw_valid,
    output logic                    aw_ready,
    input  logic [AxiIdWidth-1:0]   aw_id,
    input  logic [LEN_W-1:0]        aw_len,
    input  logic [ATOP_W-1:0]       aw_atop,
    // W
    input  logic                    w_valid,
    output logic                    w_ready,
    input  logic                    w_last,
    // B
    output logic                    b_valid,
    input  logic                    b_ready,
    output logic [AxiIdWidth-1:0]   b_id,
    output logic [1:0]              b_resp,
    // AR
    input  logic                    ar_valid,
    output logic                    ar_ready,
    input  logic [AxiIdWidth-1:0]   ar_id,
    input  logic [LEN_W-1:0]        ar_len,
    // R
    output logic                    r_valid,
    input  logic                    r_ready,
    output logic [AxiIdWidth-1:0]   r_id,
    output logic [AxiDataWidth-1:0] r_data,
    output logic [1:0]              r_resp,
    output logic                    r_last
);

    localparam int unsigned RqW = AxiIdWidth + LEN_W;
    // Cast truncates or zero-extends the 64-bit pattern to the bus width
    localparam logic [AxiDataWidth-1:0] RDataFixed = AxiDataWidth'(RespData);

    logic active;
    logic aw_atomic;
    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

    logic                  wq_push, wq_pop, wq_full, wq_empty;
    logic [AxiIdWidth-1:0] wq_head;

    logic                  rq_push, rq_pop, rq_full, rq_empty;
    logic [RqW-1:0]        rq_din, rq_head;
    logic [AxiIdWidth-1:0] rq_head_id;
    logic [LEN_W-1:0]      rq_head_len;

    logic                  br_valid_q, br_valid_d;
    logic [AxiIdWidth-1:0] br_id_q, br_id_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;

    assign active    = !rst_n;
    assign aw_atomic = aw_atop[ATOP_R_RESP];

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    // An atomic AW needs room in both queues since it also owes an R burst.
    assign aw_ready = active && !wq_full && (!aw_atomic || !rq_full);
    // A pending atomic AW owns the RQ push port this cycle, so AR waits.
    assign ar_ready = active && !rq_full && !(aw_valid && aw_atomic);
    // W is only taken once its AW is queued and the B slot can take the result.
    assign w_ready  = active && !wq_empty && (!br_valid_q || b_ready);

    assign aw_hs = aw_valid && aw_ready;
    assign ar_hs = ar_valid && ar_ready;
    assign w_hs  = w_valid  && w_ready;
    assign b_hs  = b_valid  && b_ready;
    assign r_hs  = r_valid  && r_ready;

    // ------------------------------------------------------------------
    // Transaction queues
    // ------------------------------------------------------------------
    assign wq_push = aw_hs;
    assign wq_pop  = w_hs && w_last;

    assign rq_push = (aw_hs && aw_atomic) || ar_hs;
    assign rq_din  = (aw_hs && aw_atomic) ? {aw_id, aw_len} : {ar_id, ar_len};
    assign rq_pop  = r_hs && r_last;

    assign {rq_head_id, rq_head_len} = rq_head;

    axi_err_responder_fifo #(
        .DataWidth (AxiIdWidth),
        .Depth     (MaxTrans)
    ) u_wq (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (wq_push),
        .data_i  (aw_id),
        .pop_i   (wq_pop),
        .full_o  (wq_full),
        .empty_o (wq_empty),
        .data_o  (wq_head)
    );

    axi_err_responder_fifo #(
        .DataWidth (RqW),
        .Depth     (MaxTrans)
    ) u_rq (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (rq_push),
        .data_i  (rq_din),
        .pop_i   (rq_pop),
        .full_o  (rq_full),
        .empty_o (rq_empty),
        .data_o  (rq_head)
    );

    // ------------------------------------------------------------------
    // B slot and R beat counter
    // ------------------------------------------------------------------
    always_comb begin
        br_valid_d = br_valid_q;
        br_id_d    = br_id_q;
        // A reload in the same cycle as the handshake wins over the clear.
        if (b_hs) begin
            br_valid_d = 1'b0;
        end
        if (wq_pop) begin
            br_valid_d = 1'b1;
            br_id_d    = wq_head;
        end

        cnt_d = cnt_q;
        if (r_hs) begin
            cnt_d = r_last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            br_valid_q <= 1'b0;
            br_id_q    <= '0;
            cnt_q      <= '0;
        end else begin
            br_valid_q <= br_valid_d;
            br_id_q    <= br_id_d;
            cnt_q      <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign b_valid = active && br_valid_q;
    assign b_id    = active ? br_id_q : '0;
    assign b_resp  = active ? RespVal : 2'b00;

    assign r_valid = active && !rq_empty;
    // Head payload is only meaningful with r_valid; keep the bus clean otherwise.
    assign r_id    = r_valid ? rq_head_id : '0;
    assign r_last  = r_valid && (cnt_q == rq_head_len);
    assign r_data  = active ? RDataFixed : '0;
    assign r_resp  = active ? RespVal : 2'b00;

endmodule

// File: tb/tb_axi_err_responder.sv
module tb_axi_err_responder;

    localparam int ID_W   = 4;
    localparam int DATA_W = 64;
    localparam int MT     = 8;
    localparam logic [63:0] EXP_RDATA = 64'hCA11AB1EBADCAB1E;
    localparam logic [1:0]  EXP_RESP  = 2'b11;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              aw_valid, aw_ready;
    logic [ID_W-1:0]   aw_id;
    logic [7:0]        aw_len;
    logic [5:0]        aw_atop;
    logic              w_valid, w_ready, w_last;
    logic              b_valid, b_ready;
    logic [ID_W-1:0]   b_id;
    logic [1:0]        b_resp;
    logic              ar_valid, ar_ready;
    logic [ID_W-1:0]   ar_id;
    logic [7:0]        ar_len;
    logic              r_valid, r_ready;
    logic [ID_W-1:0]   r_id;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_resp;
    logic              r_last;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int id;
        int len;
    } rtxn_t;

    rtxn_t rq_m[$];
    int    wq_m[$];
    int    bq_m[$];
    int    rbeat;

    axi_err_responder #(
        .AxiIdWidth   (ID_W),
        .AxiDataWidth (DATA_W),
        .MaxTrans     (MT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .aw_valid (aw_valid),
        .aw_ready (aw_ready),
        .aw_id    (aw_id),
        .aw_len   (aw_len),
        .aw_atop  (aw_atop),
        .w_valid  (w_valid),
        .w_ready  (w_ready),
        .w_last   (w_last),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_id     (b_id),
        .b_resp   (b_resp),
        .ar_valid (ar_valid),
        .ar_ready (ar_ready),
        .ar_id    (ar_id),
        .ar_len   (ar_len),
        .r_valid  (r_valid),
        .r_ready  (r_ready),
        .r_id     (r_id),
        .r_data   (r_data),
        .r_resp   (r_resp),
        .r_last   (r_last)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        aw_valid = 1'b0; aw_id = '0; aw_len = '0; aw_atop = '0;
        w_valid  = 1'b0; w_last = 1'b0; b_ready = 1'b0;
        ar_valid = 1'b0; ar_id = '0; ar_len = '0; r_ready = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b1;
        aw_valid = 1'b1; ar_valid = 1'b1; w_valid = 1'b1; w_last = 1'b1;
        b_ready = 1'b1; r_ready = 1'b1; aw_atop = 6'h20;
        repeat (3) tick();
        #1;
        checks++;
        if ({aw_ready, w_ready, ar_ready, b_valid, r_valid, r_last} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {aw_ready, w_ready, ar_ready, b_valid, r_valid, r_last});
        end
        checks++;
        if ({b_id, b_resp, r_id, r_resp} !== 12'h000) begin
            failures++;
            $display("FAIL reset_payload: got %h want 000", {b_id, b_resp, r_id, r_resp});
        end
        checks++;
        if (r_data !== '0) begin
            failures++;
            $display("FAIL reset_rdata: got %h want 0", r_data);
        end
        idle_inputs();
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({aw_ready, ar_ready, w_ready, b_valid, r_valid} !== 5'b11000) begin
            failures++;
            $display("FAIL post_reset_idle: got %b want 11000",
                     {aw_ready, ar_ready, w_ready, b_valid, r_valid});
        end
        $display("txn reset released");
    endtask

    task automatic test_single_write();
        aw_id = 4'd3; aw_len = 8'd3; aw_atop = '0; aw_valid = 1'b1;
        w_valid = 1'b1; w_last = 1'b0; b_ready = 1'b0;
        #1;
        checks++;
        if ({aw_ready, w_ready} !== 2'b10) begin
            failures++;
            $display("FAIL sw_aw_accept: got aw_ready,w_ready=%b want 10", {aw_ready, w_ready});
        end
        tick();
        aw_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w_last = (i == 3);
            #1;
            checks++;
            if (w_ready !== 1'b1 || b_valid !== 1'b0) begin
                failures++;
                $display("FAIL sw_w_beat%0d: got w_ready=%b b_valid=%b want 1 0", i, w_ready, b_valid);
            end
            tick();
        end
        w_valid = 1'b0; w_last = 1'b0;
        #1;
        checks++;
        if (b_valid !== 1'b1 || b_id !== 4'd3 || b_resp !== EXP_RESP) begin
            failures++;
            $display("FAIL sw_b: got v=%b id=%0d resp=%b want 1 3 11", b_valid, b_id, b_resp);
        end
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        #1;
        checks++;
        if (b_valid !== 1'b0) begin
            failures++;
            $display("FAIL sw_b_clear: got b_valid=%b want 0", b_valid);
        end
        $display("txn write id=3 len=3 -> B");
    endtask

    task automatic test_read_burst();
        ar_id = 4'd5; ar_len = 8'd7; ar_valid = 1'b1; r_ready = 1'b1;
        #1;
        checks++;
        if (ar_ready !== 1'b1 || r_valid !== 1'b0) begin
            failures++;
            $display("FAIL rb_ar: got ar_ready=%b r_valid=%b want 1 0", ar_ready, r_valid);
        end
        tick();
        ar_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++;
            if (r_valid !== 1'b1 || r_id !== 4'd5 || r_data !== EXP_RDATA ||
                r_resp !== EXP_RESP || r_last !== (i == 7)) begin
                failures++;
                $display("FAIL rb_beat%0d: got v=%b id=%0d data=%h resp=%b last=%b want 1 5 %h 11 %b",
                         i, r_valid, r_id, r_data, r_resp, r_last, EXP_RDATA, (i == 7));
            end
            tick();
        end
        #1;
        checks++;
        if (r_valid !== 1'b0) begin
            failures++;
            $display("FAIL rb_done: got r_valid=%b want 0", r_valid);
        end
        r_ready = 1'b0;
        $display("txn read id=5 len=7 -> 8 beats");
    endtask

    task automatic test_backpressure();
        int id, len;
        rq_m.delete();
        r_ready = 1'b0;
        for (int i = 0; i < MT; i++) begin
            id  = int'($urandom_range(0, 15));
            len = int'($urandom_range(0, 3));
            ar_id = ID_W'(id); ar_len = 8'(len); ar_valid = 1'b1;
            #1;
            checks++;
            if (ar_ready !== 1'b1) begin
                failures++;
                $display("FAIL bp_fill%0d: got ar_ready=%b want 1", i, ar_ready);
            end
            rq_m.push_back('{id: id, len: len});
            tick();
        end
        ar_id = 4'hF; ar_len = 8'd0; ar_valid = 1'b1;
        #1;
        checks++;
        if (ar_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_full: got ar_ready=%b want 0", ar_ready);
        end
        tick();
        ar_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (r_valid !== 1'b1 || r_id !== ID_W'(rq_m[0].id) ||
                r_last !== (rq_m[0].len == 0) || r_data !== EXP_RDATA) begin
                failures++;
                $display("FAIL bp_stall%0d: got v=%b id=%0d last=%b want 1 %0d %b",
                         i, r_valid, r_id, r_last, rq_m[0].id, (rq_m[0].len == 0));
            end
            tick();
        end
        rbeat = 0;
        for (int cyc = 0; cyc < 400 && rq_m.size() > 0; cyc++) begin
            r_ready = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (r_valid !== 1'b1 || r_id !== ID_W'(rq_m[0].id) ||
                r_last !== (rbeat == rq_m[0].len)) begin
                failures++;
                $display("FAIL bp_drain: got v=%b id=%0d last=%b want 1 %0d %b",
                         r_valid, r_id, r_last, rq_m[0].id, (rbeat == rq_m[0].len));
            end
            if (r_ready) begin
                if (rbeat == rq_m[0].len) begin
                    $display("txn read id=%0d len=%0d drained", rq_m[0].id, rq_m[0].len);
                    void'(rq_m.pop_front());
                    rbeat = 0;
                end else begin
                    rbeat++;
                end
            end
            tick();
        end
        checks++;
        if (rq_m.size() != 0) begin
            failures++;
            $display("FAIL bp_timeout: got %0d bursts left want 0", rq_m.size());
        end
        r_ready = 1'b0;
        #1;
        checks++;
        if (r_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_empty: got r_valid=%b want 0", r_valid);
        end
    endtask

    task automatic test_atomic();
        aw_valid = 1'b1; aw_atop = 6'b100000; aw_id = 4'd9; aw_len = 8'd0;
        ar_valid = 1'b1; ar_id = 4'd2; ar_len = 8'd0;
        #1;
        checks++;
        if ({aw_ready, ar_ready} !== 2'b10) begin
            failures++;
            $display("FAIL at_prio: got aw_ready,ar_ready=%b want 10", {aw_ready, ar_ready});
        end
        tick();
        aw_valid = 1'b0; aw_atop = '0; ar_valid = 1'b0;
        w_valid = 1'b1; w_last = 1'b1; b_ready = 1'b0; r_ready = 1'b1;
        #1;
        checks++;
        if (w_ready !== 1'b1 || r_valid !== 1'b1 || r_id !== 4'd9 ||
            r_last !== 1'b1 || r_resp !== EXP_RESP) begin
            failures++;
            $display("FAIL at_wr: got w_ready=%b r_valid=%b r_id=%0d r_last=%b r_resp=%b want 1 1 9 1 11",
                     w_ready, r_valid, r_id, r_last, r_resp);
        end
        tick();
        w_valid = 1'b0; w_last = 1'b0; r_ready = 1'b0;
        #1;
        checks++;
        if (b_valid !== 1'b1 || b_id !== 4'd9 || r_valid !== 1'b0) begin
            failures++;
            $display("FAIL at_b: got b_valid=%b b_id=%0d r_valid=%b want 1 9 0", b_valid, b_id, r_valid);
        end
        b_ready = 1'b1;
        tick();
        b_ready = 1'b0;
        #1;
        checks++;
        if (b_valid !== 1'b0) begin
            failures++;
            $display("FAIL at_b_clear: got b_valid=%b want 0", b_valid);
        end
        $display("txn atomic id=9 -> B and R");
    endtask

    task automatic test_early_w();
        w_valid = 1'b1; w_last = 1'b1; b_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            #1;
            checks++;
            if (w_ready !== 1'b0) begin
                failures++;
                $display("FAIL ew_stall%0d: got w_ready=%b want 0", i, w_ready);
            end
            tick();
        end
        aw_valid = 1'b1; aw_id = 4'd6; aw_len = 8'd0; aw_atop = '0;
        tick();
        aw_valid = 1'b0;
        #1;
        checks++;
        if (w_ready !== 1'b1) begin
            failures++;
            $display("FAIL ew_accept: got w_ready=%b want 1", w_ready);
        end
        tick();
        w_valid = 1'b0; w_last = 1'b0;
        #1;
        checks++;
        if (b_valid !== 1'b1 || b_id !== 4'd6) begin
            failures++;
            $display("FAIL ew_b: got b_valid=%b b_id=%0d want 1 6", b_valid, b_id);
        end
        tick();
        b_ready = 1'b0;
        #1;
        checks++;
        if (b_valid !== 1'b0) begin
            failures++;
            $display("FAIL ew_b_clear: got b_valid=%b want 0", b_valid);
        end
        $display("txn early write id=6 -> B");
    endtask

    task automatic test_reset_mid_burst();
        aw_valid = 1'b1; aw_id = 4'd1; aw_len = 8'd0; aw_atop = '0;
        tick();
        aw_valid = 1'b0;
        ar_valid = 1'b1; ar_id = 4'd4; ar_len = 8'd7; r_ready = 1'b1;
        tick();
        ar_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (r_valid !== 1'b1 || r_last !== 1'b0) begin
                failures++;
                $display("FAIL rm_beat%0d: got v=%b last=%b want 1 0", i, r_valid, r_last);
            end
            tick();
        end
        aw_valid = 1'b1; ar_valid = 1'b1;
        rst_n = 1'b1;
        #1;
        checks++;
        if ({r_valid, aw_ready, w_ready, ar_ready, b_valid} !== 5'b0) begin
            failures++;
            $display("FAIL rm_in_reset: got %b want 00000",
                     {r_valid, aw_ready, w_ready, ar_ready, b_valid});
        end
        aw_valid = 1'b0; ar_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        w_valid = 1'b1; w_last = 1'b1;
        #1;
        checks++;
        if (w_ready !== 1'b0 || r_valid !== 1'b0) begin
            failures++;
            $display("FAIL rm_flushed: got w_ready=%b r_valid=%b want 0 0", w_ready, r_valid);
        end
        w_valid = 1'b0; w_last = 1'b0;
        ar_valid = 1'b1; ar_id = 4'd7; ar_len = 8'd0;
        tick();
        ar_valid = 1'b0;
        #1;
        checks++;
        if (r_valid !== 1'b1 || r_id !== 4'd7 || r_last !== 1'b1) begin
            failures++;
            $display("FAIL rm_new_ar: got v=%b id=%0d last=%b want 1 7 1", r_valid, r_id, r_last);
        end
        tick();
        #1;
        checks++;
        if (r_valid !== 1'b0) begin
            failures++;
            $display("FAIL rm_single: got r_valid=%b want 0", r_valid);
        end
        r_ready = 1'b0;
        $display("txn reset mid-burst, then read id=7 len=0");
    endtask

    task automatic test_random();
        logic [5:0] atops [4];
        logic exp_awr, exp_arr, exp_wr, atom;
        int id;
        atops[0] = 6'h00; atops[1] = 6'h20; atops[2] = 6'h11; atops[3] = 6'h3F;
        idle_inputs();
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        rq_m.delete(); wq_m.delete(); bq_m.delete(); rbeat = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            aw_valid = ($urandom_range(0, 2) == 0);
            aw_id    = ID_W'($urandom_range(0, 15));
            aw_len   = 8'($urandom_range(0, 3));
            aw_atop  = atops[$urandom_range(0, 3)];
            w_valid  = 1'($urandom_range(0, 1));
            w_last   = ($urandom_range(0, 2) == 0);
            b_ready  = 1'($urandom_range(0, 1));
            ar_valid = ($urandom_range(0, 2) == 0);
            ar_id    = ID_W'($urandom_range(0, 15));
            ar_len   = 8'($urandom_range(0, 3));
            r_ready  = 1'($urandom_range(0, 1));
            #1;
            atom    = aw_atop[5];
            exp_awr = (wq_m.size() < MT) && (!atom || rq_m.size() < MT);
            exp_arr = (rq_m.size() < MT) && !(aw_valid && atom);
            exp_wr  = (wq_m.size() > 0) && (bq_m.size() == 0 || b_ready);
            checks++;
            if ({aw_ready, ar_ready, w_ready} !== {exp_awr, exp_arr, exp_wr}) begin
                failures++;
                $display("FAIL rnd_ready cyc%0d: got aw,ar,w=%b want %b",
                         cyc, {aw_ready, ar_ready, w_ready}, {exp_awr, exp_arr, exp_wr});
            end
            checks++;
            if (b_valid !== (bq_m.size() > 0) ||
                (bq_m.size() > 0 && (b_id !== ID_W'(bq_m[0]) || b_resp !== EXP_RESP))) begin
                failures++;
                $display("FAIL rnd_b cyc%0d: got v=%b id=%0d want v=%0d id=%0d",
                         cyc, b_valid, b_id, (bq_m.size() > 0), (bq_m.size() > 0) ? bq_m[0] : 0);
            end
            checks++;
            if (r_valid !== (rq_m.size() > 0) ||
                (rq_m.size() > 0 && (r_id !== ID_W'(rq_m[0].id) ||
                 r_last !== (rbeat == rq_m[0].len) || r_data !== EXP_RDATA))) begin
                failures++;
                $display("FAIL rnd_r cyc%0d: got v=%b id=%0d last=%b want v=%0d id=%0d last=%0d",
                         cyc, r_valid, r_id, r_last, (rq_m.size() > 0),
                         (rq_m.size() > 0) ? rq_m[0].id : 0,
                         (rq_m.size() > 0) ? (rbeat == rq_m[0].len) : 0);
            end
            // Reference model update, from the state seen before this edge
            if (r_ready && rq_m.size() > 0) begin
                if (rbeat == rq_m[0].len) begin
                    $display("txn R id=%0d len=%0d", rq_m[0].id, rq_m[0].len);
                    void'(rq_m.pop_front());
                    rbeat = 0;
                end else begin
                    rbeat++;
                end
            end
            if (b_ready && bq_m.size() > 0) begin
                $display("txn B id=%0d", bq_m[0]);
                void'(bq_m.pop_front());
            end
            if (w_valid && exp_wr && w_last) begin
                id = wq_m.pop_front();
                bq_m.push_back(id);
            end
            if (aw_valid && exp_awr) begin
                wq_m.push_back(int'(aw_id));
                if (atom) rq_m.push_back('{id: int'(aw_id), len: int'(aw_len)});
            end else if (ar_valid && exp_arr) begin
                rq_m.push_back('{id: int'(ar_id), len: int'(ar_len)});
            end
            if (ar_valid && exp_arr && aw_valid && exp_awr && !atom) begin
                rq_m.push_back('{id: int'(ar_id), len: int'(ar_len)});
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_write();
        test_read_burst();
        test_backpressure();
        test_atomic();
        test_early_w();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
